// File: rtl/divider_iterative.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH steps per operation.
// Start/done handshake: pulse valid_in, then poll valid_out (held until the next accepted start).
module divider_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH:0]   p_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             vld_q, vld_d;
  logic             dbz_q, dbz_d;
  logic             qbit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      vld_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      vld_q   <= vld_d;
      dbz_q   <= dbz_d;
    end
  end

  // The dividend register doubles as the quotient register: quotient bits enter at the LSB
  // as dividend bits leave at the MSB. The WIDTH+1 bit partial remainder never overflows.
  always_comb begin
    p_shift = {p_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    qbit    = (p_shift >= {1'b0, dvs_q});
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    vld_d   = vld_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (valid_in) begin
          dvd_d   = a;
          dvs_d   = b;
          p_d     = '0;
          cnt_d   = CW'(WIDTH);
          vld_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        p_d   = qbit ? (p_shift - {1'b0, dvs_q}) : p_shift;
        dvd_d = {dvd_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = dvd_d;
          r_d     = p_d[WIDTH-1:0];
          vld_d   = 1'b1;
          dbz_d   = (dvs_q == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_out   = vld_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Bench for divider_iterative: directed vectors with literal expectations plus an
// arithmetic reference model checked on every cycle valid_out is high.
module tb_divider_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         valid_out;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  res_t exp_fifo[$];
  res_t cur;
  logic have_cur = 1'b0;
  logic prev_vo  = 1'b0;

  divider_iterative #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .a          (a),
    .b          (b),
    .valid_out  (valid_out),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, with the divide-by-zero convention q = all ones, r = a.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t m;
    if (y == '0) begin
      m.q = '1; m.r = x; m.dbz = 1'b1;
    end else begin
      m.q = x / y; m.r = x % y; m.dbz = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Compare process: each rising valid_out consumes one queued expectation; held results re-checked.
  always @(negedge clk) begin
    if (reset) begin
      prev_vo  = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (valid_out && !prev_vo) begin
        if (exp_fifo.size() == 0) begin
          n_vec++;
          n_fail++;
          have_cur = 1'b0;
          $display("FAIL unexpected_valid_out: got valid_out=1 with q=%0h r=%0h, required no result", q, r);
        end else begin
          cur      = exp_fifo.pop_front();
          have_cur = 1'b1;
        end
      end
      if (valid_out && have_cur) begin
        chk("model_q", q, cur.q);
        chk("model_r", r, cur.r);
        chk("model_dbz", div_by_zero, cur.dbz);
      end
      prev_vo = valid_out;
    end
  end

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    @(negedge clk);
    a = x; b = y; valid_in = 1'b1;
    if (push) exp_fifo.push_back(model(x, y));
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Counts edges after the accept edge until valid_out is seen; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid_out || lat >= 100) break;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int lat;
    start(x, y, 1'b1);
    chk({name, "_vo_drop"}, valid_out, 0);
    wait_done(lat);
    chk({name, "_latency"}, lat, 32);
    chk({name, "_q"}, q, eq);
    chk({name, "_r"}, r, er);
    chk({name, "_dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    res_t m;
    int   lat;
    int   seen;
    int   waited;
    logic [W-1:0] x, y;
    logic [63:0]  recon;
    logic [W-1:0] bb_a[4];
    logic [W-1:0] bb_b[4];

    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t m;
    int   lat;
    int   seen;
    int   waited;
    logic [W-1:0] x, y;
    logic [63:0]  recon;
    logic [W-1:0] bb_a[4];
    logic [W-1:0] bb_b[4];

    // Asynchronous reset, observed before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("async_reset_vo", valid_out, 0);
    chk("async_reset_q", q, 0);
    chk("async_reset_r", r, 0);
    chk("async_reset_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_vo", valid_out, 0);
    chk("idle_q", q, 0);
    chk("idle_r", r, 0);
    chk("idle_dbz", div_by_zero, 0);

    // Pin the reference model with hand-computed values
    m = model(32'd100, 32'd7);
    chk("pin_100_7_q", m.q, 14);
    chk("pin_100_7_r", m.r, 2);
    m = model(32'h12345678, 32'd0);
    chk("pin_dbz_q", m.q, 32'hFFFFFFFF);
    chk("pin_dbz_r", m.r, 32'h12345678);
    m = model(32'hFFFFFFFE, 32'hFFFFFFFF);
    chk("pin_near_max_q", m.q, 0);
    chk("pin_near_max_r", m.r, 32'hFFFFFFFE);

    // Directed operations
    run_op("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    run_op("dbz", 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    run_op("max_by_1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op("max_by_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    run_op("near_max", 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 1'b0);

    // Start request during BUSY is ignored; operands changing afterwards have no effect
    start(32'd100, 32'd7, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    a = 32'd9; b = 32'd3; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0; a = 32'd55; b = 32'd0;
    waited = 0;
    while (!valid_out && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("ignored_start_vo", valid_out, 1);
    chk("ignored_start_q", q, 14);
    chk("ignored_start_r", r, 2);

    // Back-to-back: valid_in held high, one-cycle valid_out per result
    bb_a = '{32'd20, 32'd1000, 32'hDEADBEEF, 32'd77};
    bb_b = '{32'd6, 32'd33, 32'h00010000, 32'd10};
    @(negedge clk);
    a = bb_a[0]; b = bb_b[0]; valid_in = 1'b1;
    exp_fifo.push_back(model(bb_a[0], bb_b[0]));
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!valid_out && waited < 100);
      chk("b2b_result_seen", valid_out, 1);
      if (k < 3) begin
        a = bb_a[k+1]; b = bb_b[k+1];
        exp_fifo.push_back(model(bb_a[k+1], bb_b[k+1]));
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
      chk("b2b_vo_width", valid_out, (k < 3) ? 1'b0 : 1'b1);
    end
    chk("b2b_last_q", q, 7);
    chk("b2b_last_r", r, 7);

    // Reset mid-BUSY: outputs clear at once, aborted op never reports
    start(32'd100, 32'd7, 1'b1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    exp_fifo.delete();
    #1;
    chk("midbusy_reset_vo", valid_out, 0);
    chk("midbusy_reset_q", q, 0);
    chk("midbusy_reset_r", r, 0);
    chk("midbusy_reset_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    chk("aborted_op_silent", seen, 0);

    // Sweep: arithmetic invariant on every result
    x = 32'd1;
    y = 32'd1;
    repeat (200) begin
      start(x, y, 1'b1);
      wait_done(lat);
      n_vec++;
      if (y != '0) begin
        recon = 64'(q) * 64'(y) + 64'(r);
        if (lat != 32 || !valid_out || recon != 64'(x) || r >= y) begin
          $display("FAIL sweep a=%0h b=%0h: got q=%0h r=%0h latency=%0d, required a==q*b+r, r<b, latency 32",
                   x, y, q, r, lat);
          $fatal(1, "sweep invariant");
        end
      end else begin
        if (lat != 32 || !valid_out || q != '1 || r != x || !div_by_zero) begin
          $display("FAIL sweep_dbz a=%0h: got q=%0h r=%0h dbz=%0b, required q=ffffffff r=a dbz=1",
                   x, q, r, div_by_zero);
          $fatal(1, "sweep divide-by-zero");
        end
      end
      x = x + 32'h23456789;
      y = y + 32'h34567891;
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
